// File: rtl/rc4_key_schedule.sv
// RC4 key-scheduling stage (KSA). Walks i = 0..255 over a shared 256x8 S RAM,
// accumulating j = j + s[i] + key[i mod KEY_BYTES] and swapping s[i] / s[j].
// Six states per iteration; all RAM-facing outputs and status flags are registered.
// Optional build macro: KSA_SAME_IDX_SKIP_EN -- when defined, an iteration whose
// new j equals i skips the read/swap of s[j] (the swap would be a no-op).
module rc4_key_schedule #(
   parameter int unsigned KEY_BYTES = 3
) (
   input  logic                   clock,
   input  logic                   rst,
   input  logic                   start,
   input  logic [KEY_BYTES*8-1:0] secret_key,
   output logic [7:0]             mem_addr,
   output logic [7:0]             mem_data,
   output logic                   mem_wren,
   input  logic [7:0]             mem_q,
   output logic                   busy,
   output logic                   done
);

   localparam int unsigned KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(KEY_BYTES - 1);

   typedef enum logic [2:0] {
      StIdle, StRdI, StGetI, StRdJ, StGetJ, StWrI, StWrJ, StDone
   } state_t;

   state_t                 state;
   logic [7:0]             idx_i;
   logic [7:0]             idx_j;
   logic [KW-1:0]          key_idx;
   logic [KEY_BYTES*8-1:0] key_reg;
   logic [7:0]             s_i;

   logic [KW-1:0]          key_sh;
   logic [KEY_BYTES*8-1:0] key_shifted;
   logic [7:0]             key_byte;
   logic [7:0]             j_new;
   logic                   skip;

   // Per-iteration "advance" results, shared by WR_J and the optional skip path
   state_t                 adv_state;
   logic [7:0]             adv_i;
   logic [KW-1:0]          adv_k;
   logic                   adv_busy;
   logic                   adv_done;

   // Key byte select (byte 0 is the MS byte) and the j accumulator update
   always_comb begin
      key_sh      = K_LAST - key_idx;
      key_shifted = key_reg >> {key_sh, 3'b000};
      key_byte    = key_shifted[7:0];
      j_new       = idx_j + mem_q + key_byte;
`ifdef KSA_SAME_IDX_SKIP_EN
      skip        = (j_new == idx_i);
`else
      skip        = 1'b0;
`endif
   end

   // Next-iteration step: terminate after i == 255, otherwise bump i and wrap k
   always_comb begin
      adv_state = StRdI;
      adv_i     = idx_i + 8'd1;
      adv_k     = (key_idx == K_LAST) ? '0 : key_idx + 1'b1;
      adv_busy  = 1'b1;
      adv_done  = 1'b0;
      if (idx_i == 8'hFF) begin
         adv_state = StDone;
         adv_i     = idx_i;
         adv_k     = key_idx;
         adv_busy  = 1'b0;
         adv_done  = 1'b1;
      end
   end

   // Main FSM with registered RAM interface and status outputs
   always_ff @(posedge clock) begin
      if (rst) begin
         state    <= StIdle;
         idx_i    <= 8'd0;
         idx_j    <= 8'd0;
         key_idx  <= '0;
         key_reg  <= '0;
         s_i      <= 8'd0;
         mem_addr <= 8'd0;
         mem_data <= 8'd0;
         mem_wren <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         unique case (state)
            StIdle, StDone: begin
               if (start) begin
                  key_reg  <= secret_key;
                  idx_i    <= 8'd0;
                  idx_j    <= 8'd0;
                  key_idx  <= '0;
                  mem_addr <= 8'd0;
                  busy     <= 1'b1;
                  done     <= 1'b0;
                  state    <= StRdI;
               end
            end
            StRdI: state <= StGetI;
            StGetI: begin
               s_i   <= mem_q;
               idx_j <= j_new;
               if (skip) begin
                  state    <= adv_state;
                  idx_i    <= adv_i;
                  key_idx  <= adv_k;
                  busy     <= adv_busy;
                  done     <= adv_done;
                  mem_addr <= adv_done ? 8'd0 : adv_i;
               end else begin
                  mem_addr <= j_new;
                  state    <= StRdJ;
               end
            end
            StRdJ: state <= StGetJ;
            StGetJ: begin
               // s[j] goes straight into the write-data register for WR_I
               mem_data <= mem_q;
               mem_wren <= 1'b1;
               mem_addr <= idx_i;
               state    <= StWrI;
            end
            StWrI: begin
               mem_data <= s_i;
               mem_addr <= idx_j;
               state    <= StWrJ;
            end
            StWrJ: begin
               mem_wren <= 1'b0;
               mem_data <= 8'd0;
               state    <= adv_state;
               idx_i    <= adv_i;
               key_idx  <= adv_k;
               busy     <= adv_busy;
               done     <= adv_done;
               mem_addr <= adv_done ? 8'd0 : adv_i;
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_rc4_key_schedule.sv
// Bench for rc4_key_schedule: behavioural 1-cycle-latency S RAMs, a reference
// KSA model feeding a write/timing scoreboard, and a negedge monitor that pops it.
module tb_rc4_key_schedule;

`ifdef KSA_SAME_IDX_SKIP_EN
   localparam bit SKIP = 1'b1;
`else
   localparam bit SKIP = 1'b0;
`endif

   logic        clock = 1'b0;
   logic        rst;
   logic        start_a, start_b;
   logic [23:0] key_a;
   logic [7:0]  key_b;
   logic [7:0]  addr_a, data_a, q_a, addr_b, data_b, q_b;
   logic        wren_a, busy_a, done_a, wren_b, busy_b, done_b;

   always #5 clock = ~clock;

   rc4_key_schedule #(.KEY_BYTES(3)) dut_a (
      .clock(clock), .rst(rst), .start(start_a), .secret_key(key_a),
      .mem_addr(addr_a), .mem_data(data_a), .mem_wren(wren_a), .mem_q(q_a),
      .busy(busy_a), .done(done_a)
   );

   rc4_key_schedule #(.KEY_BYTES(1)) dut_b (
      .clock(clock), .rst(rst), .start(start_b), .secret_key(key_b),
      .mem_addr(addr_b), .mem_data(data_b), .mem_wren(wren_b), .mem_q(q_b),
      .busy(busy_b), .done(done_b)
   );

   logic [7:0] ram_a [256];
   logic [7:0] ram_b [256];

   always @(posedge clock) begin
      q_a <= ram_a[addr_a];
      if (wren_a) ram_a[addr_a] = data_a;
   end

   always @(posedge clock) begin
      q_b <= ram_b[addr_b];
      if (wren_b) ram_b[addr_b] = data_b;
   end

   int          checks;
   int          failures;
   logic [15:0] exp_wr_q[$];
   int          exp_cyc_q[$];
   int          exp_wcnt_q[$];
   logic [7:0]  ms [256];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   // Reference RC4 KSA; optionally queues expected writes and run length
   task automatic model_run(input logic [23:0] key, input int len, input bit fresh,
                            input bit push);
      logic [7:0]  j, kb, t;
      logic [23:0] sh;
      int          cyc, wr;
      if (fresh) for (int n = 0; n < 256; n++) ms[n] = n[7:0];
      j = 8'd0; cyc = 0; wr = 0;
      for (int n = 0; n < 256; n++) begin
         sh = key >> (8 * (len - 1 - (n % len)));
         kb = sh[7:0];
         j  = j + ms[n] + kb;
         if (SKIP && j == n[7:0]) begin
            cyc += 2;
         end else begin
            if (push) begin
               exp_wr_q.push_back({n[7:0], ms[j]});
               exp_wr_q.push_back({j, ms[n]});
            end
            t = ms[n]; ms[n] = ms[j]; ms[j] = t;
            cyc += 6; wr += 2;
         end
      end
      if (push) begin
         exp_cyc_q.push_back(cyc);
         exp_wcnt_q.push_back(wr);
      end
   endtask

   task automatic init_ram(input bit sel);
      for (int n = 0; n < 256; n++) begin
         if (sel) ram_b[n] = n[7:0];
         else     ram_a[n] = n[7:0];
      end
   endtask

   task automatic compare_ram(input string name, input bit sel);
      int bad, first;
      logic [7:0] v;
      bad = 0; first = 0;
      for (int n = 0; n < 256; n++) begin
         v = sel ? ram_b[n] : ram_a[n];
         if (v !== ms[n]) begin
            if (bad == 0) first = n;
            bad++;
         end
      end
      checks++;
      if (bad != 0) begin
         failures++;
         v = sel ? ram_b[first] : ram_a[first];
         $display("FAIL %s: %0d bytes differ, s[%0d] got %0h required %0h",
                  name, bad, first, v, ms[first]);
      end
   endtask

   task automatic wait_done(input string name, input bit sel);
      int n;
      n = 0;
      while (!(sel ? done_b : done_a) && n < 4000) begin
         @(negedge clock);
         n++;
      end
      checks++;
      if (!(sel ? done_b : done_a)) begin
         failures++;
         $display("FAIL %s: done got 0 after %0d cycles, required 1", name, n);
      end
   endtask

   task automatic pulse_start(input bit sel);
      @(negedge clock);
      if (sel) start_b = 1'b1; else start_a = 1'b1;
      @(posedge clock);
      #1;
      start_a = 1'b0;
      start_b = 1'b0;
   endtask

   // Monitor: pops expected writes and per-run cycle/write counts for dut_a
   int   busy_cnt, wr_cnt;
   bit   seen_both, prev_busy, prev_done;
   logic [15:0] e_wr;

   always @(negedge clock) begin
      if (rst) begin
         busy_cnt = 0; wr_cnt = 0; seen_both = 0; prev_busy = 0; prev_done = 0;
      end else begin
         if (busy_a && done_a) seen_both = 1;
         if (wren_a) begin
            wr_cnt++;
            if (exp_wr_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_write: got addr %0h data %0h, required no write",
                        addr_a, data_a);
            end else begin
               e_wr = exp_wr_q.pop_front();
               check("write_addr_data", {16'h0, addr_a, data_a}, {16'h0, e_wr});
            end
         end
         if (done_a && !prev_done) begin
            if (exp_cyc_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_done: got done=1, required no run in progress");
            end else begin
               check("busy_cycles", busy_cnt, exp_cyc_q.pop_front());
               check("write_cycles", wr_cnt, exp_wcnt_q.pop_front());
               check("busy_done_overlap", {31'h0, seen_both}, 32'h0);
               check("done_follows_busy", {31'h0, prev_busy}, 32'h1);
            end
            busy_cnt = 0; wr_cnt = 0; seen_both = 0;
         end
         if (busy_a) busy_cnt++;
         prev_busy = busy_a;
         prev_done = done_a;
      end
   end

   initial begin
      int w1, w2;
      checks = 0; failures = 0;
      rst = 1'b1; start_a = 1'b0; start_b = 1'b0; key_a = 24'h0; key_b = 8'h0;
      // Cycles to the end of iteration 2 (iterations 0/1 skip in the skip build)
      w1 = SKIP ? 10 : 18;
      w2 = SKIP ? 14 : 18;
      init_ram(1'b0);
      init_ram(1'b1);
      repeat (3) @(posedge clock);
      @(negedge clock);
      check("reset_busy", {31'h0, busy_a}, 32'h0);
      check("reset_done", {31'h0, done_a}, 32'h0);
      check("reset_wren", {31'h0, wren_a}, 32'h0);
      check("reset_addr", {24'h0, addr_a}, 32'h0);
      check("reset_data", {24'h0, data_a}, 32'h0);
      check("reset_busy_b", {30'h0, busy_b, done_b}, 32'h0);
      rst = 1'b0;

      // Run 1: key 000000 on identity S; start pulse while busy must be ignored
      model_run(24'h000000, 3, 1'b1, 1'b1);
      key_a = 24'h000000;
      pulse_start(1'b0);
      repeat (w1) @(posedge clock);
      #1;
      check("k0_s0", {24'h0, ram_a[0]}, 32'h00);
      check("k0_s1", {24'h0, ram_a[1]}, 32'h01);
      check("k0_s2", {24'h0, ram_a[2]}, 32'h03);
      check("k0_s3", {24'h0, ram_a[3]}, 32'h02);
      @(negedge clock) start_a = 1'b1;
      @(negedge clock) start_a = 1'b0;
      wait_done("run_k0_done", 1'b0);
      compare_ram("final_s_k000000", 1'b0);

      // Run 2: key 000102, then start held high through DONE for an immediate restart
      init_ram(1'b0);
      model_run(24'h000102, 3, 1'b1, 1'b1);
      key_a = 24'h000102;
      pulse_start(1'b0);
      repeat (w2) @(posedge clock);
      #1;
      check("k012_s1", {24'h0, ram_a[1]}, 32'h02);
      check("k012_s2", {24'h0, ram_a[2]}, 32'h05);
      check("k012_s5", {24'h0, ram_a[5]}, 32'h01);
      model_run(24'h000102, 3, 1'b0, 1'b1);
      @(negedge clock) start_a = 1'b1;
      wait_done("run_k012_done", 1'b0);
      @(posedge clock);
      #1;
      check("restart_done_drops", {31'h0, done_a}, 32'h0);
      check("restart_busy", {31'h0, busy_a}, 32'h1);
      start_a = 1'b0;
      wait_done("run_restart_done", 1'b0);
      compare_ram("final_s_restart", 1'b0);

      // Run 3: synchronous reset mid-iteration, then no further writes
      init_ram(1'b0);
      model_run(24'h5A1234, 3, 1'b1, 1'b1);
      key_a = 24'h5A1234;
      pulse_start(1'b0);
      repeat (100) @(posedge clock);
      @(negedge clock) rst = 1'b1;
      @(posedge clock);
      #1;
      rst = 1'b0;
      exp_wr_q.delete();
      exp_cyc_q.delete();
      exp_wcnt_q.delete();
      check("midrst_busy", {31'h0, busy_a}, 32'h0);
      check("midrst_done", {31'h0, done_a}, 32'h0);
      check("midrst_wren", {31'h0, wren_a}, 32'h0);
      repeat (20) @(negedge clock);
      check("midrst_idle_busy", {31'h0, busy_a}, 32'h0);

      // Run 4: KEY_BYTES=1 instance, key FF
      init_ram(1'b1);
      model_run(24'h0000FF, 1, 1'b1, 1'b0);
      key_b = 8'hFF;
      pulse_start(1'b1);
      wait_done("run_kb1_done", 1'b1);
      check("kb1_busy_low", {31'h0, busy_b}, 32'h0);
      compare_ram("final_s_kb1_ff", 1'b1);

      repeat (2) @(negedge clock);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
